// File: rtl/bar_graph_pkg.sv
// Shared definitions for the bar-graph sequencer: register map,
// animation modes and CTRL field positions.
package bar_graph_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PATTERN = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_BRI_LO  = 4;
    localparam int CTRL_BRI_HI  = 7;

endpackage

// File: rtl/bar_graph_step.sv
// Next-frame function for one animation step; purely combinational
// so it can be checked over every (mode, frame, dir) combination.
module bar_graph_step
    import bar_graph_pkg::*;
(
    input  mode_t      mode,
    input  logic [7:0] frame,
    input  logic       dir,
    output logic [7:0] next_frame,
    output logic       next_dir
);

    always_comb begin
        next_frame = frame;
        next_dir   = dir;
        unique case (mode)
            MODE_STATIC: next_frame = frame;
            MODE_ROTATE: next_frame = {frame[6:0], frame[7]};
            MODE_BOUNCE: begin
                // Reverse at the end LED so the lit bit reflects off the edge
                if (!dir) begin
                    if (frame[7]) begin
                        next_dir   = 1'b1;
                        next_frame = frame >> 1;
                    end else begin
                        next_frame = frame << 1;
                    end
                end else begin
                    if (frame[0]) begin
                        next_dir   = 1'b0;
                        next_frame = frame << 1;
                    end else begin
                        next_frame = frame >> 1;
                    end
                end
            end
            MODE_COUNT:  next_frame = frame + 8'd1;
        endcase
    end

endmodule

// File: rtl/bar_graph_seq_wb.sv
// Wishbone-controlled LED bar-graph sequencer: register file, step
// prescaler, frame animation and PWM dimming of the 8 LED outputs.
module bar_graph_seq_wb
    import bar_graph_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 2,
    parameter int          DATA_WIDTH     = 16,
    parameter logic [15:0] DEFAULT_PERIOD = 16'd49999
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [7:0]            bar_graph,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_strobe,
    input  logic                  wbs_write,
    input  logic                  wbs_cycle,
    output logic                  wbs_ack
);

    logic        enable;
    mode_t       mode;
    logic [3:0]  brightness;
    logic [7:0]  frame;
    logic        dir;
    logic [15:0] prescaler;
    logic [15:0] period;
    logic [3:0]  pwm_cnt;

    logic        req;
    logic        wr;
    logic        tick;
    logic [1:0]  sel;
    logic [15:0] wdata;
    logic [7:0]  step_frame;
    logic        step_dir;
    logic [15:0] rd_mux;

    assign sel   = wbs_address[1:0];
    assign wdata = wbs_writedata[15:0];
    assign req   = wbs_cycle & wbs_strobe & ~wbs_ack;
    assign wr    = req & wbs_write;
    assign tick  = enable && (prescaler == period);

    bar_graph_step u_step (
        .mode       (mode),
        .frame      (frame),
        .dir        (dir),
        .next_frame (step_frame),
        .next_dir   (step_dir)
    );

    always_comb begin
        rd_mux = 16'h0000;
        unique case (sel)
            REG_CTRL:    rd_mux = {8'h00, brightness, 1'b0, mode, enable};
            REG_PATTERN: rd_mux = {8'h00, frame};
            REG_PERIOD:  rd_mux = period;
            REG_STATUS:  rd_mux = {6'b0, enable, dir, frame};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            enable       <= 1'b0;
            mode         <= MODE_STATIC;
            brightness   <= 4'hF;
            frame        <= 8'h00;
            dir          <= 1'b0;
            prescaler    <= 16'h0000;
            period       <= DEFAULT_PERIOD;
            pwm_cnt      <= 4'h0;
            wbs_ack      <= 1'b0;
            wbs_readdata <= '0;
            bar_graph    <= 8'h00;
        end else begin
            wbs_ack <= req;
            if (req) begin
                wbs_readdata <= DATA_WIDTH'(rd_mux);
            end

            if (wr && sel == REG_CTRL) begin
                enable     <= wdata[CTRL_EN];
                mode       <= mode_t'(wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
                brightness <= wdata[CTRL_BRI_HI:CTRL_BRI_LO];
            end

            if (wr && sel == REG_PERIOD) begin
                period <= wdata;
            end

            if (!enable) begin
                prescaler <= 16'h0000;
            end else if (wr && sel == REG_PERIOD) begin
                prescaler <= 16'h0000;
            end else if (tick) begin
                prescaler <= 16'h0000;
            end else begin
                prescaler <= prescaler + 16'd1;
            end

            // A host pattern load overrides any step due this cycle
            if (wr && sel == REG_PATTERN) begin
                frame <= wdata[7:0];
                dir   <= 1'b0;
            end else if (tick) begin
                frame <= step_frame;
                dir   <= step_dir;
            end

            pwm_cnt   <= pwm_cnt + 4'd1;
            bar_graph <= frame & {8{pwm_cnt <= brightness}};
        end
    end

endmodule

// File: tb/tb_bar_graph_seq_wb.sv
// Scoreboard bench for the bar-graph sequencer: expected read data
// and LED frames are queued by stimulus and compared by a monitor.
module tb_bar_graph_seq_wb;
    import bar_graph_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bar_graph;
    logic [1:0]  wbs_address;
    logic [15:0] wbs_writedata;
    logic [15:0] wbs_readdata;
    logic        wbs_strobe;
    logic        wbs_write;
    logic        wbs_cycle;
    logic        wbs_ack;

    always #5 clk = ~clk;

    bar_graph_seq_wb dut (
        .clk           (clk),
        .reset         (reset),
        .bar_graph     (bar_graph),
        .wbs_address   (wbs_address),
        .wbs_writedata (wbs_writedata),
        .wbs_readdata  (wbs_readdata),
        .wbs_strobe    (wbs_strobe),
        .wbs_write     (wbs_write),
        .wbs_cycle     (wbs_cycle),
        .wbs_ack       (wbs_ack)
    );

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        int          addr;
    } rd_t;

    rd_t        rd_q[$];
    logic [7:0] bg_q[$];
    rd_t        ent;
    logic [7:0] bg_exp;
    bit         prev_req = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         xfers = 0;
    int         acks = 0;

    // Monitor: handshake timing, read data and LED frames
    always @(negedge clk) begin
        if (prev_req) begin
            checks++;
            if (wbs_ack !== 1'b1) begin
                errors++;
                $display("FAIL ack_latency ack=%b required=1", wbs_ack);
            end
        end else if (wbs_ack === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack ack=1 required=0");
        end
        if (wbs_ack === 1'b1) begin
            acks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack queue empty");
            end else begin
                ent = rd_q.pop_front();
                if (ent.chk) begin
                    checks++;
                    if (wbs_readdata !== ent.exp) begin
                        errors++;
                        $display("FAIL read_reg%0d got %h required %h",
                                 ent.addr, wbs_readdata, ent.exp);
                    end
                end
            end
        end
        if (bg_q.size() > 0) begin
            bg_exp = bg_q.pop_front();
            checks++;
            if (bar_graph !== bg_exp) begin
                errors++;
                $display("FAIL bar_graph got %h required %h",
                         bar_graph, bg_exp);
            end
        end
        prev_req = wbs_cycle & wbs_strobe & ~wbs_ack;
    end

    task automatic wb(input bit we, input logic [1:0] a,
                      input logic [15:0] d, input bit chk,
                      input logic [15:0] exp);
        rd_q.push_back('{chk, exp, int'(a)});
        xfers++;
        @(posedge clk);
        #1;
        wbs_cycle     = 1'b1;
        wbs_strobe    = 1'b1;
        wbs_write     = we;
        wbs_address   = a;
        wbs_writedata = d;
        @(posedge clk);
        #1;
        wbs_cycle  = 1'b0;
        wbs_strobe = 1'b0;
        wbs_write  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wb(1'b1, a, d, 1'b0, 16'h0000);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp);
        wb(1'b0, a, 16'h0000, 1'b1, exp);
    endtask

    task automatic chk(input string n, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", n, got, exp);
        end
    endtask

    task automatic push_bg(input logic [7:0] v);
        bg_q.push_back(v);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (bg_q.size() == 0 && rd_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (bg_q.size() != 0 || rd_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout bg=%0d rd=%0d required 0",
                     bg_q.size(), rd_q.size());
        end
    endtask

    int on_cnt;
    int off_cnt;
    logic [7:0] frame_seq[6];

    initial begin
        reset         = 1'b0;
        wbs_cycle     = 1'b0;
        wbs_strobe    = 1'b0;
        wbs_write     = 1'b0;
        wbs_address   = 2'd0;
        wbs_writedata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bar_graph", {8'h00, bar_graph}, 16'h0000);
        chk("reset_ack", {15'h0, wbs_ack}, 16'h0000);
        reset = 1'b1;

        rd(REG_CTRL, 16'h00F0);
        rd(REG_PATTERN, 16'h0000);
        rd(REG_PERIOD, 16'hC34F);
        rd(REG_STATUS, 16'h0000);

        // Rotate every clock
        wr(REG_PERIOD, 16'h0000);
        wr(REG_PATTERN, 16'h0081);
        wr(REG_CTRL, 16'h00F3);
        push_bg(8'h81); push_bg(8'h81); push_bg(8'h03);
        push_bg(8'h06); push_bg(8'h0C);
        repeat (5) @(posedge clk);
        #1;

        // Bounce, one step every 2 clocks
        wr(REG_CTRL, 16'h00F0);
        wr(REG_PATTERN, 16'h0040);
        wr(REG_PERIOD, 16'h0001);
        wr(REG_CTRL, 16'h00F5);
        push_bg(8'h40); push_bg(8'h40); push_bg(8'h40);
        push_bg(8'h80); push_bg(8'h80); push_bg(8'h40);
        push_bg(8'h40); push_bg(8'h20); push_bg(8'h20);
        repeat (9) @(posedge clk);
        #1;
        wr(REG_CTRL, 16'h00F0);
        rd(REG_STATUS, 16'h0108);

        // Binary count with wrap, then freeze
        wr(REG_PATTERN, 16'h00FE);
        wr(REG_PERIOD, 16'h0000);
        wr(REG_CTRL, 16'h00F7);
        push_bg(8'hFE); push_bg(8'hFE); push_bg(8'hFF);
        push_bg(8'h00); push_bg(8'h01);
        repeat (5) @(posedge clk);
        #1;
        wr(REG_CTRL, 16'h00F6);
        rd(REG_STATUS, 16'h0005);
        rd(REG_CTRL, 16'h00F6);
        repeat (10) @(posedge clk);
        #1;
        rd(REG_PATTERN, 16'h0005);

        // Re-enable: prescaler restarts from 0
        wr(REG_PERIOD, 16'h0003);
        wr(REG_CTRL, 16'h00F7);
        for (int i = 0; i < 5; i++) push_bg(8'h05);
        push_bg(8'h06);
        repeat (6) @(posedge clk);
        #1;
        wr(REG_CTRL, 16'h00F6);
        rd(REG_STATUS, 16'h0007);

        // Pattern load on a tick, then mode change on a tick
        wr(REG_PERIOD, 16'h0000);
        wr(REG_CTRL, 16'h00F3);
        repeat (3) @(posedge clk);
        #1;
        wr(REG_PATTERN, 16'h005A);
        @(posedge clk);
        #1;
        frame_seq = '{8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hD3, 8'hD4};
        foreach (frame_seq[i]) push_bg(frame_seq[i]);
        wr(REG_CTRL, 16'h00F7);
        wait_drain();

        // Brightness 3: on for 4 of 16 clocks
        wr(REG_CTRL, 16'h0030);
        wr(REG_PATTERN, 16'h00FF);
        repeat (2) @(posedge clk);
        on_cnt  = 0;
        off_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bar_graph === 8'hFF) on_cnt++;
            else if (bar_graph === 8'h00) off_cnt++;
        end
        chk("pwm_on_count", 16'(on_cnt), 16'd4);
        chk("pwm_off_count", 16'(off_cnt), 16'd12);

        // Reset mid-animation
        wr(REG_CTRL, 16'h00F3);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_bar_graph", {8'h00, bar_graph}, 16'h00FF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_bar_graph", {8'h00, bar_graph}, 16'h0000);
        chk("mid_reset_ack", {15'h0, wbs_ack}, 16'h0000);
        chk("mid_reset_readdata", wbs_readdata, 16'h0000);
        reset = 1'b1;
        rd(REG_CTRL, 16'h00F0);
        rd(REG_PATTERN, 16'h0000);
        rd(REG_PERIOD, 16'hC34F);
        rd(REG_STATUS, 16'h0000);

        wr(REG_STATUS, 16'hFFFF);
        rd(REG_STATUS, 16'h0000);

        wait_drain();
        chk("ack_count", 16'(acks), 16'(xfers));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
